// File: rtl/pgm_bus_pkg.sv
// Shared types and helpers for the 68k program-ROM port: FSM states,
// ROM window bounds and line/word address helpers.
package pgm_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        REL,
        ACK,
        DRAIN
    } pgm_state_t;

    localparam logic [23:0] PGM_ROM_BASE = 24'h000000;
    localparam logic [23:0] PGM_ROM_TOP  = 24'h3FFFFF;

    // 16-bit word of a 64-bit line; word 0 is the lowest byte address.
    function automatic logic [15:0] line_word(input logic [63:0] line, input logic [1:0] sel);
        logic [15:0] w;
        case (sel)
            2'd0:    w = line[15:0];
            2'd1:    w = line[31:16];
            2'd2:    w = line[47:32];
            default: w = line[63:48];
        endcase
        return w;
    endfunction

    // Line address (byte bits [23:3]) of a 68k word address folded into the ROM window.
    function automatic logic [20:0] rom_line(input logic [22:0] adr);
        logic [23:0] off;
        off = ({adr, 1'b0} - PGM_ROM_BASE) & (PGM_ROM_TOP - PGM_ROM_BASE);
        return 21'(off >> 3);
    endfunction

endpackage

// File: rtl/pgm_sync_bit.sv
// Level synchronizer: STAGES flops deep, reset to RST_VAL so a level that may
// still be high from before reset is treated as high until proven otherwise.
module pgm_sync_bit #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic fixed_20m_clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge fixed_20m_clk) begin
        if (reset) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pgm_rom_port.sv
// 68k BIOS/P-ROM read responder with a one-line buffer fed by a req/ack
// handshake to the SDRAM arbiter. Define PGM_ROM_LINE_CACHE_EN to enable line hits.
module pgm_rom_port
    import pgm_bus_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LINE_AW     = 21
) (
    input  logic               fixed_20m_clk,
    input  logic               reset,
    input  logic               cpu_as_n,
    input  logic               cpu_rw_n,
    input  logic               cpu_sel,
    input  logic [22:0]        cpu_adr,
    output logic [15:0]        cpu_din,
    output logic               cpu_dtack_n,
    input  logic               flush,
    output logic               mem_req,
    output logic [LINE_AW-1:0] mem_addr,
    input  logic               mem_ack,
    input  logic [63:0]        mem_data,
    output logic               busy
);

    pgm_state_t         state_q, state_d;
    logic               dtack_n_q, dtack_n_d;
    logic [15:0]        din_q, din_d;
    logic               mem_req_q, mem_req_d;
    logic [LINE_AW-1:0] mem_addr_q, mem_addr_d;
    logic [63:0]        line_q, line_d;
    logic               served_q, served_d;
    logic               write_q, write_d;

    logic               ack_s;
    logic               start;
    logic               hit;
    logic               capture;
    logic [LINE_AW-1:0] req_line;

    pgm_sync_bit #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_ack_sync (
        .fixed_20m_clk (fixed_20m_clk),
        .reset         (reset),
        .d_i           (mem_ack),
        .q_o           (ack_s)
    );

    assign req_line = rom_line(cpu_adr);
    assign start    = !cpu_as_n && cpu_sel && (state_q == IDLE) && !served_q;
    assign capture  = (state_q == REQ) && ack_s;

`ifdef PGM_ROM_LINE_CACHE_EN
    logic               line_valid_q, line_valid_d;
    logic [LINE_AW-1:0] tag_q, tag_d;

    // flush is applied last so it beats a capture in the same cycle
    always_comb begin
        line_valid_d = line_valid_q;
        tag_d        = tag_q;
        if (capture) begin
            line_valid_d = 1'b1;
            tag_d        = mem_addr_q;
        end
        if (flush) begin
            line_valid_d = 1'b0;
        end
    end

    always_ff @(posedge fixed_20m_clk) begin
        if (reset) begin
            line_valid_q <= 1'b0;
            tag_q        <= '0;
        end else begin
            line_valid_q <= line_valid_d;
            tag_q        <= tag_d;
        end
    end

    assign hit = line_valid_q && (tag_q == req_line);
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign hit          = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        dtack_n_d  = dtack_n_q;
        din_d      = din_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        line_d     = line_q;
        served_d   = served_q;
        write_d    = write_q;

        if (cpu_as_n) begin
            served_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    write_d = !cpu_rw_n;
                    if (!cpu_rw_n || hit) begin
                        state_d = ACK;
                    end else if (!ack_s) begin
                        mem_addr_d = req_line;
                        mem_req_d  = 1'b1;
                        state_d    = REQ;
                    end
                end
            end
            REQ: begin
                if (capture) begin
                    line_d    = mem_data;
                    mem_req_d = 1'b0;
                    state_d   = REL;
                end
            end
            REL: begin
                // an abandoned strobe still keeps the freshly captured line
                if (!ack_s) begin
                    state_d = cpu_as_n ? IDLE : ACK;
                end
            end
            ACK: begin
                if (cpu_as_n) begin
                    dtack_n_d = 1'b1;
                    din_d     = 16'hFFFF;
                    state_d   = IDLE;
                end else begin
                    dtack_n_d = 1'b0;
                    din_d     = write_q ? 16'hFFFF : line_word(line_q, cpu_adr[1:0]);
                    served_d  = 1'b1;
                end
            end
            DRAIN: begin
                mem_req_d = 1'b0;
                if (!ack_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = DRAIN;
            end
        endcase
    end

    always_ff @(posedge fixed_20m_clk) begin
        if (reset) begin
            state_q    <= DRAIN;
            dtack_n_q  <= 1'b1;
            din_q      <= 16'hFFFF;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            line_q     <= '0;
            served_q   <= 1'b0;
            write_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dtack_n_q  <= dtack_n_d;
            din_q      <= din_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            line_q     <= line_d;
            served_q   <= served_d;
            write_q    <= write_d;
        end
    end

    assign cpu_din     = din_q;
    assign cpu_dtack_n = dtack_n_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_pgm_rom_port.sv
// Directed bench for pgm_rom_port: CPU strobe driver, arbiter responder and a
// per-cycle monitor checking against a line-level cache model.
`timescale 1ns/1ps
module tb_pgm_rom_port;

    localparam int SYNC_STAGES = 2;
    localparam int LINE_AW     = 21;
    localparam int ACK_DLY     = 6;
    localparam int REL_DLY     = 3;
`ifdef PGM_ROM_LINE_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic               clk      = 1'b0;
    logic               reset    = 1'b1;
    logic               cpu_as_n = 1'b1;
    logic               cpu_rw_n = 1'b1;
    logic               cpu_sel  = 1'b0;
    logic [22:0]        cpu_adr  = '0;
    logic               flush    = 1'b0;
    logic               mem_ack  = 1'b0;
    logic [63:0]        mem_data = '0;
    logic [15:0]        cpu_din;
    logic               cpu_dtack_n;
    logic               mem_req;
    logic [LINE_AW-1:0] mem_addr;
    logic               busy;

    always #25 clk = ~clk;

    pgm_rom_port #(
        .SYNC_STAGES (SYNC_STAGES),
        .LINE_AW     (LINE_AW)
    ) dut (
        .fixed_20m_clk (clk),
        .reset         (reset),
        .cpu_as_n      (cpu_as_n),
        .cpu_rw_n      (cpu_rw_n),
        .cpu_sel       (cpu_sel),
        .cpu_adr       (cpu_adr),
        .cpu_din       (cpu_din),
        .cpu_dtack_n   (cpu_dtack_n),
        .flush         (flush),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_data      (mem_data),
        .busy          (busy)
    );

    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    bit          req_allowed = 1'b0;
    logic [15:0] cur_word = 16'hFFFF;
    logic [20:0] cur_line = '0;
    int          dtack_edges = 0;
    int          req_edges = 0;
    logic [20:0] last_req_addr = '0;
    bit          m_valid = 1'b0;
    logic [20:0] m_tag = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ROM contents as seen by the arbiter
    function automatic logic [63:0] mem_line(input logic [20:0] line);
        if (line == 21'h020000) return 64'h4444_3333_2222_1111;
        return {16'hD000 ^ line[15:0], 16'hC000 ^ line[15:0],
                16'hB000 ^ line[15:0], 16'hA000 ^ line[15:0]};
    endfunction

    function automatic logic [15:0] mem_word(input logic [23:0] baddr);
        logic [63:0] l;
        l = mem_line(baddr[23:3]);
        return l[baddr[2:1]*16 +: 16];
    endfunction

    int arb_cnt = 0;
    always @(posedge clk) begin
        if (mem_req && !mem_ack) begin
            arb_cnt++;
            if (arb_cnt >= ACK_DLY) begin
                arb_cnt = 0;
                #1;
                mem_data = mem_line(mem_addr);
                mem_ack  = 1'b1;
            end
        end else if (!mem_req && mem_ack) begin
            arb_cnt++;
            if (arb_cnt >= REL_DLY) begin
                arb_cnt = 0;
                #1;
                mem_ack = 1'b0;
            end
        end else begin
            arb_cnt = 0;
        end
    end

    bit as_prev = 1'b1, dtack_prev = 1'b1, req_prev = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (!cpu_dtack_n) chk("din", {48'h0, cpu_din}, {48'h0, cur_word});
            if (as_prev) chk("dtack_while_as_high", {63'h0, cpu_dtack_n}, 64'h1);
            if (dtack_prev && !cpu_dtack_n) dtack_edges++;
            if (mem_req) begin
                chk("req_allowed", {63'h0, mem_req}, {63'h0, req_allowed});
                chk("mem_addr", {43'h0, mem_addr}, {43'h0, cur_line});
                if (!req_prev) begin
                    req_edges++;
                    last_req_addr = mem_addr;
                end
            end
        end
        as_prev    = cpu_as_n;
        dtack_prev = cpu_dtack_n;
        req_prev   = mem_req;
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 300);
        #1;
        chk(name, {63'h0, busy}, 64'h0);
    endtask

    // One CPU strobe. abort_cyc>0 releases AS that many clocks after it fell.
    task automatic strobe(input logic [23:0] baddr, input bit is_rd, input int hold,
                          input int abort_cyc, input bit flush_cap,
                          output logic [15:0] got_din);
        bit exp_req;
        int n;
        exp_req     = is_rd && !(CACHE && m_valid && m_tag == baddr[23:3]);
        cur_word    = is_rd ? mem_word(baddr) : 16'hFFFF;
        cur_line    = baddr[23:3];
        req_allowed = exp_req;
        dtack_edges = 0;
        req_edges   = 0;
        got_din     = 16'hFFFF;
        @(posedge clk);
        #1;
        cpu_adr  = baddr[23:1];
        cpu_rw_n = is_rd;
        cpu_sel  = 1'b1;
        cpu_as_n = 1'b0;
        if (flush_cap) begin
            n = 0;
            while (!mem_ack && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("flush_cap_ack_seen", {63'h0, mem_ack}, 64'h1);
            repeat (SYNC_STAGES) @(posedge clk);
            #1 flush = 1'b1;
            @(posedge clk);
            #1 flush = 1'b0;
        end
        if (abort_cyc > 0) begin
            repeat (abort_cyc) @(posedge clk);
            #1 cpu_as_n = 1'b1;
        end else begin
            n = 0;
            do begin
                @(posedge clk);
                n++;
                #1;
            end while (cpu_dtack_n && n < 300);
            got_din = cpu_din;
            chk("dtack_seen", {63'h0, cpu_dtack_n}, 64'h0);
            if (!exp_req) chk("short_latency", n, 2);
            repeat (hold) @(posedge clk);
            @(posedge clk);
            #1 cpu_as_n = 1'b1;
        end
        cpu_sel = 1'b0;
        wait_idle("strobe_idle");
        chk("dtack_count", dtack_edges, (abort_cyc > 0) ? 0 : 1);
        chk("req_count", req_edges, exp_req ? 1 : 0);
        req_allowed = 1'b0;
        if (exp_req) begin
            m_valid = !flush_cap;
            m_tag   = baddr[23:3];
        end
        $display("strobe adr=%06h rd=%0d din=%04h dtacks=%0d reqs=%0d", baddr, is_rd, got_din,
                 dtack_edges, req_edges);
    endtask

    task automatic flush_pulse();
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        m_valid = 1'b0;
        $display("flush pulse");
    endtask

    task automatic reset_mid_request(input logic [23:0] baddr);
        int n;
        cur_line    = baddr[23:3];
        cur_word    = mem_word(baddr);
        req_allowed = 1'b1;
        dtack_edges = 0;
        @(posedge clk);
        #1;
        cpu_adr  = baddr[23:1];
        cpu_rw_n = 1'b1;
        cpu_sel  = 1'b1;
        cpu_as_n = 1'b0;
        n = 0;
        while (!mem_ack && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst_ack_seen", {63'h0, mem_ack}, 64'h1);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        cpu_as_n = 1'b1;
        cpu_sel  = 1'b0;
        @(posedge clk);
        #1;
        reset       = 1'b0;
        req_allowed = 1'b0;
        m_valid     = 1'b0;
        n = 0;
        while (mem_ack && n < 100) begin
            @(negedge clk);
            chk("drain_req_low", {63'h0, mem_req}, 64'h0);
            chk("drain_busy", {63'h0, busy}, 64'h1);
            n++;
        end
        chk("drain_ack_released", {63'h0, mem_ack}, 64'h0);
        wait_idle("drain_idle");
        chk("drain_no_dtack", dtack_edges, 0);
        $display("reset mid-request adr=%06h drain_cycles=%0d", baddr, n);
    endtask

    initial begin
        logic [15:0] d;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dtack_n", {63'h0, cpu_dtack_n}, 64'h1);
        chk("rst_din", {48'h0, cpu_din}, 64'hFFFF);
        chk("rst_mem_req", {63'h0, mem_req}, 64'h0);
        chk("rst_mem_addr", {43'h0, mem_addr}, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h1);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_idle("rst_idle");
        mon_en = 1'b1;

        strobe(24'h100004, 1'b1, 0, 0, 1'b0, d);
        chk("miss_din_lit", {48'h0, d}, 64'h3333);
        chk("miss_addr_lit", {43'h0, last_req_addr}, 64'h020000);
        strobe(24'h100006, 1'b1, 0, 0, 1'b0, d);
        chk("second_din_lit", {48'h0, d}, 64'h4444);

        strobe(24'h000010, 1'b0, 0, 0, 1'b0, d);
        chk("write_din_lit", {48'h0, d}, 64'hFFFF);

        strobe(24'h200008, 1'b1, 0, 2, 1'b0, d);
        strobe(24'h20000A, 1'b1, 0, 0, 1'b0, d);

        strobe(24'h200008, 1'b1, 0, 0, 1'b0, d);
        flush_pulse();
        strobe(24'h200008, 1'b1, 0, 0, 1'b0, d);

        strobe(24'h300010, 1'b1, 0, 0, 1'b1, d);
        strobe(24'h300012, 1'b1, 0, 0, 1'b0, d);

        strobe(24'h080000, 1'b1, 3, 0, 1'b0, d);
        strobe(24'h080002, 1'b1, 3, 0, 1'b0, d);
        strobe(24'h000020, 1'b0, 3, 0, 1'b0, d);

        reset_mid_request(24'h0C0000);
        strobe(24'h0C0000, 1'b1, 0, 0, 1'b0, d);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #(50 * 60000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
